// File: rtl/raiden_pkg.sv
// Shared types and constants for the enemy scheduler.
// Holds the scheduler state enum, column limits and LCG constants.
package raiden_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SPAWN,
        S_PATROL,
        S_DEAD
    } state_t;

    localparam logic [2:0] POS_MIN   = 3'd1;
    localparam logic [2:0] POS_MAX   = 3'd6;
    localparam logic [2:0] POS_RESET = 3'd3;

    localparam logic [31:0] LCG_MUL = 32'd1103515245;
    localparam logic [31:0] LCG_INC = 32'd12345;

    function automatic logic [31:0] lcg_step(input logic [31:0] r);
        return r * LCG_MUL + LCG_INC;
    endfunction

endpackage

// File: rtl/enemy_lcg.sv
// 32-bit linear congruential generator for enemy movement.
// Ports: clk; load (sync load of SEED); step (advance one); value (current r).
module enemy_lcg
    import raiden_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        load,
    input  logic        step,
    output logic [31:0] value
);

    always_ff @(posedge clk) begin
        if (load) begin
            value <= SEED;
        end else if (step) begin
            value <= lcg_step(value);
        end
    end

endmodule

// File: rtl/enemy_sched.sv
// Enemy game-step scheduler: spawn, patrol, hit/death, timed respawn.
// Ports: clk, rst (sync, active high), tick, game_en, shot_valid/shot_col in;
//   enemy_pos, enemy_alive, hit_pulse, hit_count out;
//   fire_valid/fire_col out with fire_ready in (active with ENEMY_FIRE_EN).
// Build option: define ENEMY_FIRE_EN to enable enemy shots.
module enemy_sched
    import raiden_pkg::*;
#(
    parameter int unsigned MOVE_DIV      = 2,
    parameter int unsigned FIRE_DIV      = 8,
    parameter int unsigned RESPAWN_TICKS = 4,
    parameter logic [31:0] SEED          = 32'h0000_0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       game_en,
    input  logic       shot_valid,
    input  logic [2:0] shot_col,
    output logic [2:0] enemy_pos,
    output logic       enemy_alive,
    output logic       hit_pulse,
    output logic [7:0] hit_count,
    output logic       fire_valid,
    output logic [2:0] fire_col,
    input  logic       fire_ready
);

    localparam logic [15:0] MV_LAST   = 16'(MOVE_DIV - 1);
    localparam logic [15:0] RESP_LOAD = 16'(RESPAWN_TICKS);

    state_t      state_q, state_d;
    logic [15:0] move_cnt, mc_d;
    logic [15:0] resp_cnt, rc_d;
    logic [2:0]  pos_d, pos_mv;
    logic        alive_d, hp_d;
    logic [7:0]  hc_d;
    logic        hit, move_step, dir;
    logic [31:0] lcg_value, lcg_nxt;
    logic        unused_bits;

    assign hit = (state_q == S_PATROL) && shot_valid &&
                 ((shot_col == enemy_pos - 3'd1) ||
                  (shot_col == enemy_pos) ||
                  (shot_col == enemy_pos + 3'd1));

    // A kill in the same cycle as a move tick suppresses the move.
    assign move_step = game_en && (state_q == S_PATROL) && !hit &&
                       tick && (move_cnt == MV_LAST);

    enemy_lcg #(.SEED(SEED)) u_lcg (
        .clk   (clk),
        .load  (rst),
        .step  (move_step),
        .value (lcg_value)
    );

    // Direction comes from the value the LCG is about to hold.
    assign lcg_nxt = lcg_step(lcg_value);
    assign dir     = lcg_nxt[16];

    always_comb begin
        pos_mv = enemy_pos;
        if (!dir) begin
            pos_mv = (enemy_pos < POS_MAX) ? enemy_pos + 3'd1 : enemy_pos - 3'd1;
        end else begin
            pos_mv = (enemy_pos > POS_MIN) ? enemy_pos - 3'd1 : enemy_pos + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!game_en) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:   state_d = S_SPAWN;
                S_SPAWN:  state_d = S_PATROL;
                S_PATROL: if (hit) state_d = S_DEAD;
                S_DEAD:   if (tick && resp_cnt <= 16'd1) state_d = S_SPAWN;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pos_d   = enemy_pos;
        alive_d = enemy_alive;
        hp_d    = 1'b0;
        hc_d    = hit_count;
        mc_d    = move_cnt;
        rc_d    = resp_cnt;
        if (!game_en) begin
            pos_d   = POS_RESET;
            alive_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    pos_d   = POS_RESET;
                    alive_d = 1'b0;
                end
                S_SPAWN: begin
                    pos_d   = POS_RESET;
                    alive_d = 1'b1;
                    mc_d    = 16'd0;
                end
                S_PATROL: begin
                    if (hit) begin
                        alive_d = 1'b0;
                        hp_d    = 1'b1;
                        hc_d    = (hit_count == 8'hFF) ? hit_count : hit_count + 8'd1;
                        rc_d    = RESP_LOAD;
                    end else if (tick) begin
                        if (move_cnt == MV_LAST) begin
                            mc_d  = 16'd0;
                            pos_d = pos_mv;
                        end else begin
                            mc_d = move_cnt + 16'd1;
                        end
                    end
                end
                S_DEAD: begin
                    if (tick && resp_cnt != 16'd0) rc_d = resp_cnt - 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enemy_pos   <= POS_RESET;
            enemy_alive <= 1'b0;
            hit_pulse   <= 1'b0;
            hit_count   <= 8'd0;
            move_cnt    <= 16'd0;
            resp_cnt    <= 16'd0;
        end else begin
            enemy_pos   <= pos_d;
            enemy_alive <= alive_d;
            hit_pulse   <= hp_d;
            hit_count   <= hc_d;
            move_cnt    <= mc_d;
            resp_cnt    <= rc_d;
        end
    end

`ifdef ENEMY_FIRE_EN
    localparam logic [15:0] FR_LAST = 16'(FIRE_DIV - 1);

    logic [15:0] fire_cnt, fcnt_d;
    logic        fv_d;
    logic [2:0]  fcol_d;

    always_comb begin
        fcnt_d = fire_cnt;
        fv_d   = fire_valid;
        fcol_d = fire_col;
        if (game_en && state_q == S_PATROL && !hit) begin
            if (fire_valid && fire_ready) fv_d = 1'b0;
            if (tick) begin
                if (fire_cnt == FR_LAST) begin
                    fcnt_d = 16'd0;
                    // A fire event while a shot is pending is dropped.
                    if (!fire_valid) begin
                        fv_d   = 1'b1;
                        fcol_d = enemy_pos;
                    end
                end else begin
                    fcnt_d = fire_cnt + 16'd1;
                end
            end
        end else begin
            // Leaving patrol withdraws any pending shot.
            fv_d   = 1'b0;
            fcnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fire_cnt   <= 16'd0;
            fire_valid <= 1'b0;
            fire_col   <= 3'd0;
        end else begin
            fire_cnt   <= fcnt_d;
            fire_valid <= fv_d;
            fire_col   <= fcol_d;
        end
    end

    assign unused_bits = ^{lcg_nxt[31:17], lcg_nxt[15:0]};
`else
    assign fire_valid  = 1'b0;
    assign fire_col    = 3'd0;
    assign unused_bits = ^{lcg_nxt[31:17], lcg_nxt[15:0], fire_ready};
`endif

endmodule

// File: tb/tb_enemy_sched.sv
// Scoreboard bench for enemy_sched: stimulus queues expectations,
// monitors pop and compare as the DUT presents outputs.
module tb_enemy_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       game_en = 1'b0;
    logic       shot_valid = 1'b0;
    logic [2:0] shot_col = 3'd0;
    logic       fire_ready = 1'b0;
    logic [2:0] enemy_pos;
    logic       enemy_alive;
    logic       hit_pulse;
    logic [7:0] hit_count;
    logic       fire_valid;
    logic [2:0] fire_col;

    enemy_sched dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .game_en     (game_en),
        .shot_valid  (shot_valid),
        .shot_col    (shot_col),
        .enemy_pos   (enemy_pos),
        .enemy_alive (enemy_alive),
        .hit_pulse   (hit_pulse),
        .hit_count   (hit_count),
        .fire_valid  (fire_valid),
        .fire_col    (fire_col),
        .fire_ready  (fire_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        string      tag;
        int         due;
        bit         kind;
        bit         pos_chk;
        logic [2:0] pos;
        logic       alive;
        logic       hp;
        logic [7:0] hc;
        logic       fv;
        logic [2:0] fc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] hitq[$];

    task automatic push_main(input string tag, input int due, input bit pc,
                             input logic [2:0] p, input logic a,
                             input logic h, input logic [7:0] c);
        exp_t e;
        e.tag = tag; e.due = due; e.kind = 1'b0; e.pos_chk = pc;
        e.pos = p; e.alive = a; e.hp = h; e.hc = c;
        e.fv = 1'b0; e.fc = 3'd0;
        q.push_back(e);
    endtask

    task automatic push_fire(input string tag, input int due,
                             input logic v, input logic [2:0] c);
        exp_t e;
        e.tag = tag; e.due = due; e.kind = 1'b1; e.pos_chk = 1'b0;
        e.pos = 3'd0; e.alive = 1'b0; e.hp = 1'b0; e.hc = 8'd0;
        e.fv = v; e.fc = c;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic kill(input logic [2:0] col, input logic [7:0] c);
        shot_valid = 1'b1;
        shot_col   = col;
        hitq.push_back(c);
        step();
        shot_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            total++;
            if (e.due < cyc) begin
                bad++;
                $display("FAIL %s: checked late at cycle %0d, due %0d", e.tag, cyc, e.due);
            end else if (e.kind == 1'b0) begin
                if ((e.pos_chk && enemy_pos !== e.pos) || enemy_alive !== e.alive ||
                    hit_pulse !== e.hp || hit_count !== e.hc) begin
                    bad++;
                    $display("FAIL %s: got pos=%0d alive=%0d hp=%0d hc=%0d want pos=%0d alive=%0d hp=%0d hc=%0d",
                             e.tag, enemy_pos, enemy_alive, hit_pulse, hit_count,
                             e.pos, e.alive, e.hp, e.hc);
                end
            end else begin
                if (fire_valid !== e.fv || (e.fv && fire_col !== e.fc)) begin
                    bad++;
                    $display("FAIL %s: got fv=%0d fc=%0d want fv=%0d fc=%0d",
                             e.tag, fire_valid, fire_col, e.fv, e.fc);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] c;
        if (hit_pulse === 1'b1) begin
            total++;
            if (hitq.size() == 0) begin
                bad++;
                $display("FAIL hit_unexpected: got hit_pulse=1 hc=%0d want no hit", hit_count);
            end else begin
                c = hitq.pop_front();
                if (hit_count !== c) begin
                    bad++;
                    $display("FAIL hit_count: got %0d want %0d", hit_count, c);
                end
            end
        end
    end

    bit         walk_on = 1'b0;
    logic [3:0] prev = 4'd3;
    int         moves = 0;
    int         lo_seen = 0;
    int         hi_seen = 0;

    always @(negedge clk) begin
        logic [3:0] p;
        if (walk_on) begin
            p = {1'b0, enemy_pos};
            total++;
            if (p < 4'd1 || p > 4'd6) begin
                bad++;
                $display("FAIL walk_range: got pos=%0d want 1..6", p);
            end
            if (p != prev) begin
                moves++;
                total++;
                if ((prev == 4'd6 && p != 4'd5) || (prev == 4'd1 && p != 4'd2) ||
                    (p != prev + 4'd1 && p != prev - 4'd1)) begin
                    bad++;
                    $display("FAIL walk_step: got %0d -> %0d want a +-1 step inside 1..6", prev, p);
                end
                if (prev == 4'd6) hi_seen++;
                if (prev == 4'd1) lo_seen++;
            end
            prev = p;
        end
    end

`ifndef ENEMY_FIRE_EN
    always @(negedge clk) begin
        if (cyc > 2) begin
            total++;
            if (fire_valid !== 1'b0 || fire_col !== 3'd0) begin
                bad++;
                $display("FAIL fire_off: got fv=%0d fc=%0d want 0 0", fire_valid, fire_col);
            end
        end
    end
`endif

`ifdef ENEMY_FIRE_EN
    function automatic logic [31:0] lcg(input logic [31:0] r);
        return r * 32'd1103515245 + 32'd12345;
    endfunction
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        push_main("reset", cyc, 1, 3'd3, 0, 0, 8'd0);

        rst = 1'b0;
        game_en = 1'b1;
        step();
        push_main("spawn_state", cyc, 1, 3'd3, 0, 0, 8'd0);
        step();
        push_main("patrol_entry", cyc, 1, 3'd3, 1, 0, 8'd0);

        do_tick();
        push_main("tick1_nomove", cyc, 1, 3'd3, 1, 0, 8'd0);
        do_tick();
        push_main("move1_dir0", cyc, 1, 3'd4, 1, 0, 8'd0);

        shot_valid = 1'b1;
        shot_col = 3'd2;
        push_main("miss_left", cyc + 1, 1, 3'd4, 1, 0, 8'd0);
        step();
        shot_col = 3'd6;
        push_main("miss_right", cyc + 1, 1, 3'd4, 1, 0, 8'd0);
        step();
        shot_valid = 1'b0;

        push_main("hit", cyc + 1, 1, 3'd4, 0, 1, 8'd1);
        kill(3'd5, 8'd1);
        push_main("hit_once", cyc + 1, 1, 3'd4, 0, 0, 8'd1);
        step();

        shot_valid = 1'b1;
        shot_col = 3'd4;
        push_main("dead_shot_ignored", cyc + 1, 1, 3'd4, 0, 0, 8'd1);
        step();
        shot_valid = 1'b0;

        do_tick();
        do_tick();
        do_tick();
        push_main("dead_after3", cyc, 1, 3'd4, 0, 0, 8'd1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        push_main("spawn_after4", cyc, 0, 3'd0, 0, 0, 8'd1);
        step();
        push_main("respawn", cyc, 1, 3'd3, 1, 0, 8'd1);

        do_tick();
        do_tick();
        push_main("move2_dir0", cyc, 1, 3'd4, 1, 0, 8'd1);

        game_en = 1'b0;
        push_main("game_off", cyc + 1, 1, 3'd3, 0, 0, 8'd1);
        step();
        step();
        push_main("idle_hold", cyc, 1, 3'd3, 0, 0, 8'd1);
        game_en = 1'b1;
        step();
        step();
        push_main("reenter", cyc, 1, 3'd3, 1, 0, 8'd1);

        do_tick();
        tick = 1'b1;
        push_main("hit_on_move", cyc + 1, 1, 3'd3, 0, 1, 8'd2);
        kill(3'd3, 8'd2);
        tick = 1'b0;
        step();

        for (int n = 3; n <= 256; n++) begin
            game_en = 1'b0;
            step();
            game_en = 1'b1;
            step();
            step();
            kill(3'd3, (n > 255) ? 8'd255 : 8'(n));
        end
        push_main("saturate", cyc, 1, 3'd3, 0, 1, 8'd255);

        do_tick();
        rst = 1'b1;
        push_main("rst_dead", cyc + 1, 1, 3'd3, 0, 0, 8'd0);
        step();
        rst = 1'b0;
        step();
        step();
        do_tick();
        do_tick();
        push_main("lcg_reseeded", cyc, 1, 3'd4, 1, 0, 8'd0);

        rst = 1'b1;
        shot_valid = 1'b1;
        shot_col = 3'd4;
        push_main("rst_over_shot", cyc + 1, 1, 3'd3, 0, 0, 8'd0);
        step();
        shot_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();

        prev = 4'd3;
        walk_on = 1'b1;
        tick = 1'b1;
        for (int i = 0; i < 10000; i++) step();
        tick = 1'b0;
        step();
        walk_on = 1'b0;
        total++;
        if (moves != 5000 || lo_seen == 0 || hi_seen == 0) begin
            bad++;
            $display("FAIL walk_summary: got moves=%0d lo=%0d hi=%0d want 5000 >0 >0",
                     moves, lo_seen, hi_seen);
        end

`ifdef ENEMY_FIRE_EN
        begin
            logic [31:0] r;
            logic [2:0]  mpos, pre, fc_exp;
            int          mc;
            rst = 1'b1;
            step();
            step();
            rst = 1'b0;
            fire_ready = 1'b0;
            step();
            step();
            r = 32'h0000_0001;
            mpos = 3'd3;
            mc = 0;
            fc_exp = 3'd0;
            for (int t = 1; t <= 24; t++) begin
                pre = mpos;
                tick = 1'b1;
                step();
                tick = 1'b0;
                mc++;
                if (mc == 2) begin
                    mc = 0;
                    r = lcg(r);
                    if (!r[16]) mpos = (mpos < 3'd6) ? mpos + 3'd1 : mpos - 3'd1;
                    else        mpos = (mpos > 3'd1) ? mpos - 3'd1 : mpos + 3'd1;
                end
                if (t == 8 || t == 24) fc_exp = pre;
                if (t <= 16) push_fire("fire_hold", cyc, (t >= 8), fc_exp);
                else         push_fire("fire_rearm", cyc, (t >= 24), fc_exp);
                step();
                if (t == 16) begin
                    fire_ready = 1'b1;
                    push_fire("fire_accept", cyc + 1, 1'b0, fc_exp);
                    step();
                    fire_ready = 1'b0;
                end
            end
            push_fire("fire_withdraw", cyc + 1, 1'b0, fc_exp);
            kill(mpos, 8'd1);
            step();
        end
`endif

        step();
        step();
        total++;
        if (q.size() != 0 || hitq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d checks and %0d hits pending want 0 0",
                     q.size(), hitq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
